sbox_byte_sequencer: RTL and testbench

//  Streams the NBYTES shared bytes of an AES state, one byte per cycle, through a

---
 rtl/sbox_byte_sequencer.sv | 133 +++++++++++++
 tb/tb_sbox_byte_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_byte_sequencer.sv
// sbox_byte_sequencer
//   Streams the NBYTES shared bytes of an AES state, one per cycle, through an
//   external pipelined DOM-masked S-box and collects the shared outputs into a
//   result register, then pulses DonexSO. Shares are never recombined here.
// Ports
//   ClkxCI      clock, rising edge
//   RstxBI      asynchronous active-low reset
//   StartxSI    start request, honoured only in IDLE
//   StatexDI    byte b share s at [(b*SHARES+s)*8 +: 8], sampled with start
//   BusyxSO     high while a run is in progress (state != IDLE)
//   DonexSO     one-cycle pulse once every byte has been captured
//   ResultxDO   shared S-box outputs, same packing as StatexDI
//   SboxInxDO   registered S-box input, share s at [s*8 +: 8]
//   SboxOutxDI  S-box output, SBOX_LATENCY cycles after the matching input
//   RandEnxSO   advances the fresh-mask PRNG while the S-box pipe is in use
module sbox_byte_sequencer #(
  parameter int SHARES       = 2,
  parameter int NBYTES       = 16,
  parameter int SBOX_LATENCY = 5
) (
  input  logic                       ClkxCI,
  input  logic                       RstxBI,
  input  logic                       StartxSI,
  input  logic [8*SHARES*NBYTES-1:0] StatexDI,
  output logic                       BusyxSO,
  output logic                       DonexSO,
  output logic [8*SHARES*NBYTES-1:0] ResultxDO,
  output logic [8*SHARES-1:0]        SboxInxDO,
  input  logic [8*SHARES-1:0]        SboxOutxDI,
  output logic                       RandEnxSO
);

  localparam int W  = 8 * SHARES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

  // Tag travelling alongside each S-box input so the output can be steered
  // into the right result byte without knowing anything about the S-box.
  typedef struct packed {
    logic          vld;
    logic [CW-1:0] idx;
  } tag_t;

  state_e                      state, state_nxt;
  logic [NBYTES*W-1:0]         pend;     // bytes not yet issued, next one in the low slot
  logic [CW-1:0]               cnt;
  logic [W-1:0]                sbox_in;
  tag_t                        tag_cur;
  tag_t [SBOX_LATENCY:1]       tag_pipe;
  tag_t                        head;
  logic [NBYTES-1:0][W-1:0]    result;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge ClkxCI or negedge RstxBI)
    if (!RstxBI) state <= IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (StartxSI) state_nxt = FEED;
      FEED:    if (cnt == LAST) state_nxt = DRAIN;
      DRAIN:   if (head.vld && head.idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign BusyxSO   = (state != IDLE);
  assign DonexSO   = (state == DONE);
  assign RandEnxSO = (state == FEED) || (state == DRAIN);

  // ---------------------------------------------------------------- feed
  // The S-box input register is loaded one edge ahead of the cycle it is
  // shown in, so byte 0 is picked straight off StatexDI at the start edge and
  // the remaining bytes are shifted down out of pend one per FEED cycle.
  always_ff @(posedge ClkxCI or negedge RstxBI)
    if (!RstxBI) begin
      pend    <= '0;
      cnt     <= '0;
      sbox_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (StartxSI) begin
            sbox_in <= StatexDI[W-1:0];
            pend    <= StatexDI >> W;
            cnt     <= '0;
          end else begin
            sbox_in <= '0;
          end
        end
        FEED: begin
          cnt     <= cnt + CW'(1);
          pend    <= pend >> W;
          sbox_in <= (cnt == LAST) ? '0 : pend[W-1:0];
        end
        default: sbox_in <= '0;
      endcase
    end

  assign SboxInxDO = sbox_in;

  // ---------------------------------------------------------------- tags
  always_comb begin
    tag_cur     = '0;
    tag_cur.vld = (state == FEED);
    tag_cur.idx = cnt;
  end

  always_ff @(posedge ClkxCI or negedge RstxBI)
    if (!RstxBI) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[1] <= tag_cur;
      for (int i = 2; i <= SBOX_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end

  // Head tag lines up with SboxOutxDI of the same cycle.
  assign head = tag_pipe[SBOX_LATENCY];

  // ---------------------------------------------------------------- capture
  for (genvar b = 0; b < NBYTES; b++) begin : g_cap
    always_ff @(posedge ClkxCI or negedge RstxBI)
      if (!RstxBI)                                result[b] <= '0;
      else if (head.vld && head.idx == CW'(b))    result[b] <= SboxOutxDI;
  end

  assign ResultxDO = result;

endmodule

// File: tb/tb_sbox_byte_sequencer.sv
module tb_sbox_byte_sequencer;

  localparam int SH  = 2;
  localparam int NB  = 16;
  localparam int LAT = 5;
  localparam int W   = 8 * SH;
  localparam logic [127:0] FIPS_V = 128'h76ABD7FE2B670130C56F6BF27B777C63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT (16 bytes)
  logic            start = 1'b0;
  logic [NB*W-1:0] state_in = '0;
  logic            busy, done, rand_en;
  logic [NB*W-1:0] result;
  logic [W-1:0]    sb_in, sb_out;

  // single-byte DUT
  logic            start1 = 1'b0;
  logic [W-1:0]    state_in1 = '0;
  logic            busy1, done1, rand_en1;
  logic [W-1:0]    result1;
  logic [W-1:0]    sb_in1, sb_out1;

  sbox_byte_sequencer #(.SHARES(SH), .NBYTES(NB), .SBOX_LATENCY(LAT)) dut (
    .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(start), .StatexDI(state_in),
    .BusyxSO(busy), .DonexSO(done), .ResultxDO(result),
    .SboxInxDO(sb_in), .SboxOutxDI(sb_out), .RandEnxSO(rand_en));

  sbox_byte_sequencer #(.SHARES(SH), .NBYTES(1), .SBOX_LATENCY(LAT)) dut1 (
    .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(start1), .StatexDI(state_in1),
    .BusyxSO(busy1), .DonexSO(done1), .ResultxDO(result1),
    .SboxInxDO(sb_in1), .SboxOutxDI(sb_out1), .RandEnxSO(rand_en1));

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------- reference S-box
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[x] = s;
    end
  endfunction

  function automatic logic [7:0] recomb(logic [W-1:0] x);
    return x[7:0] ^ x[15:8];
  endfunction

  // Masked S-box behaviour: fresh mask on share 1, share 0 carries the rest.
  function automatic logic [W-1:0] sbox_masked(logic [W-1:0] x);
    logic [7:0] m = 8'($urandom);
    return {m, sbox_tab[recomb(x)] ^ m};
  endfunction

  function automatic logic [NB*W-1:0] mask_bytes(logic [NB*8-1:0] plain);
    logic [NB*W-1:0] v;
    for (int k = 0; k < NB; k++) begin
      logic [7:0] m = 8'($urandom);
      v[k*W +: W] = {m, plain[k*8 +: 8] ^ m};
    end
    return v;
  endfunction

  function automatic logic [NB*8-1:0] rand_plain();
    logic [NB*8-1:0] p;
    for (int k = 0; k < NB; k++) p[k*8 +: 8] = 8'($urandom);
    return p;
  endfunction

  // ---------------------------------------------------------------- external S-box models
  logic [W-1:0] sbp  [1:LAT];
  logic [W-1:0] sbp1 [1:LAT];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 1; i <= LAT; i++) sbp[i] <= '0;
    end else begin
      sbp[1] <= sbox_masked(sb_in);
      for (int i = 2; i <= LAT; i++) sbp[i] <= sbp[i-1];
    end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 1; i <= LAT; i++) sbp1[i] <= '0;
    end else begin
      sbp1[1] <= sbox_masked(sb_in1);
      for (int i = 2; i <= LAT; i++) sbp1[i] <= sbp1[i-1];
    end

  assign sb_out  = sbp[LAT];
  assign sb_out1 = sbp1[LAT];

  // ---------------------------------------------------------------- run driver
  logic         busy_log [64];
  logic         done_log [64];
  logic         rand_log [64];
  logic [W-1:0] sbin_log [64];
  logic            rst_busy;
  logic [NB*W-1:0] rst_res;

  // Cycle c is the clock period in which Start is held when sched[c]=1.
  // Outputs are sampled at the falling edge of each cycle before driving.
  task automatic drive_run(input logic [NB*W-1:0] a, input logic [NB*W-1:0] b,
                           input logic [63:0] sched, input int ncyc, input int rst_cyc);
    bit first = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      busy_log[c] = busy;
      done_log[c] = done;
      rand_log[c] = rand_en;
      sbin_log[c] = sb_in;
      if (rst_cyc >= 0 && c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        rst_busy = busy;
        rst_res  = result;
      end
      if (rst_cyc >= 0 && c == rst_cyc + 3) rst_n = 1'b1;
      if (sched[c]) begin
        start    = 1'b1;
        state_in = first ? a : b;
        first    = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      start     = 1'b1;
      start1    = 1'b1;
      state_in  = mask_bytes(rand_plain());
      state_in1 = 16'($urandom);
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (rand_en !== 1'b0) begin n_fail++; $display("FAIL reset_randen got %b want 0", rand_en); end
    n_checks++; if (sb_in !== '0)     begin n_fail++; $display("FAIL reset_sboxin got %h want 0", sb_in); end
    n_checks++; if (result !== '0)    begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    n_checks++; if (busy1 !== 1'b0 || result1 !== '0)
      begin n_fail++; $display("FAIL reset_dut1 busy %b result %h want 0/0", busy1, result1); end
    start  = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got %b want 0", busy); end
  endtask

  task automatic test_fips();
    logic [NB*8-1:0] plain;
    logic [127:0]    fips = FIPS_V;
    for (int k = 0; k < NB; k++) plain[k*8 +: 8] = 8'(k);
    drive_run(mask_bytes(plain), '0, 64'h1, 30, -1);
    for (int c = 0; c < 30; c++) begin
      logic eb = (c >= 1 && c <= NB + LAT + 1);
      logic ed = (c == NB + LAT + 1);
      logic er = (c >= 1 && c <= NB + LAT);
      n_checks++; if (busy_log[c] !== eb) begin n_fail++; $display("FAIL fips_busy c%0d got %b want %b", c, busy_log[c], eb); end
      n_checks++; if (done_log[c] !== ed) begin n_fail++; $display("FAIL fips_done c%0d got %b want %b", c, done_log[c], ed); end
      n_checks++; if (rand_log[c] !== er) begin n_fail++; $display("FAIL fips_randen c%0d got %b want %b", c, rand_log[c], er); end
    end
    for (int k = 0; k < NB; k++) begin
      n_checks++;
      if (recomb(sbin_log[1+k]) !== 8'(k))
        begin n_fail++; $display("FAIL fips_sboxin byte%0d got %h want %h", k, recomb(sbin_log[1+k]), 8'(k)); end
    end
    for (int c = NB + 1; c <= NB + LAT; c++) begin
      n_checks++;
      if (sbin_log[c] !== '0) begin n_fail++; $display("FAIL fips_drain_in c%0d got %h want 0", c, sbin_log[c]); end
    end
    for (int k = 0; k < NB; k++) begin
      n_checks++;
      if (recomb(result[k*W +: W]) !== fips[k*8 +: 8])
        begin n_fail++; $display("FAIL fips_result byte%0d got %h want %h", k, recomb(result[k*W +: W]), fips[k*8 +: 8]); end
    end
  endtask

  task automatic test_masked_zero();
    logic [NB*8-1:0] plain = '0;
    plain[5*8 +: 8] = 8'h53;
    drive_run(mask_bytes(plain), '0, 64'h1, 25, -1);
    n_checks++; if (done_log[22] !== 1'b1) begin n_fail++; $display("FAIL mz_done got %b want 1", done_log[22]); end
    for (int k = 0; k < NB; k++) begin
      logic [7:0] e = (k == 5) ? 8'hED : 8'h63;
      n_checks++;
      if (recomb(result[k*W +: W]) !== e)
        begin n_fail++; $display("FAIL mz_result byte%0d got %h want %h", k, recomb(result[k*W +: W]), e); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      logic [NB*8-1:0] plain = rand_plain();
      drive_run(mask_bytes(plain), '0, 64'h1, 24, -1);
      for (int k = 0; k < NB; k++) begin
        logic [7:0] e = sbox_tab[plain[k*8 +: 8]];
        n_checks++;
        if (recomb(result[k*W +: W]) !== e)
          begin n_fail++; $display("FAIL rand%0d_result byte%0d got %h want %h", r, k, recomb(result[k*W +: W]), e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NB*8-1:0] pa = rand_plain();
    logic [NB*8-1:0] pb = rand_plain();
    logic [63:0] sched = '0;
    sched[0] = 1'b1; sched[5] = 1'b1; sched[22] = 1'b1; sched[23] = 1'b1;
    drive_run(mask_bytes(pa), mask_bytes(pb), sched, 50, -1);
    for (int c = 0; c < 50; c++) begin
      logic ed = (c == 22 || c == 45);
      logic eb = (c >= 1 && c <= 22) || (c >= 24 && c <= 45);
      n_checks++; if (done_log[c] !== ed) begin n_fail++; $display("FAIL b2b_done c%0d got %b want %b", c, done_log[c], ed); end
      n_checks++; if (busy_log[c] !== eb) begin n_fail++; $display("FAIL b2b_busy c%0d got %b want %b", c, busy_log[c], eb); end
    end
    for (int k = 0; k < NB; k++) begin
      logic [7:0] e = sbox_tab[pb[k*8 +: 8]];
      n_checks++;
      if (recomb(result[k*W +: W]) !== e)
        begin n_fail++; $display("FAIL b2b_result byte%0d got %h want %h", k, recomb(result[k*W +: W]), e); end
    end
  endtask

  task automatic test_reset_midrun();
    logic [NB*8-1:0] plain = rand_plain();
    drive_run(mask_bytes(rand_plain()), '0, 64'h1, 30, 10);
    n_checks++; if (rst_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", rst_busy); end
    n_checks++; if (rst_res !== '0)    begin n_fail++; $display("FAIL midrst_result got %h want 0", rst_res); end
    for (int c = 11; c < 30; c++) begin
      n_checks++; if (done_log[c] !== 1'b0) begin n_fail++; $display("FAIL midrst_done c%0d got %b want 0", c, done_log[c]); end
      n_checks++; if (busy_log[c] !== 1'b0) begin n_fail++; $display("FAIL midrst_idle c%0d got %b want 0", c, busy_log[c]); end
    end
    drive_run(mask_bytes(plain), '0, 64'h1, 24, -1);
    n_checks++; if (done_log[22] !== 1'b1) begin n_fail++; $display("FAIL midrst_rerun_done got %b want 1", done_log[22]); end
    for (int k = 0; k < NB; k++) begin
      logic [7:0] e = sbox_tab[plain[k*8 +: 8]];
      n_checks++;
      if (recomb(result[k*W +: W]) !== e)
        begin n_fail++; $display("FAIL midrst_result byte%0d got %h want %h", k, recomb(result[k*W +: W]), e); end
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] m = 8'($urandom);
    for (int c = 0; c < 13; c++) begin
      logic eb = (c >= 1 && c <= 7);
      logic ed = (c == 7);
      logic er = (c >= 1 && c <= 6);
      @(negedge clk);
      n_checks++; if (busy1 !== eb)    begin n_fail++; $display("FAIL nb1_busy c%0d got %b want %b", c, busy1, eb); end
      n_checks++; if (done1 !== ed)    begin n_fail++; $display("FAIL nb1_done c%0d got %b want %b", c, done1, ed); end
      n_checks++; if (rand_en1 !== er) begin n_fail++; $display("FAIL nb1_randen c%0d got %b want %b", c, rand_en1, er); end
      if (c == 0) begin start1 = 1'b1; state_in1 = {m, m}; end
      else        start1 = 1'b0;
    end
    n_checks++;
    if (recomb(result1) !== 8'h63) begin n_fail++; $display("FAIL nb1_result got %h want 63", recomb(result1)); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_masked_zero();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    test_single_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, got timeout want finish");
    $fatal(1);
  end

endmodule
